// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the pooling write-back path.
package pool_pkg;
    localparam int POOL_NUM_D = 16;
    localparam int DATA_W_D   = 8;
    localparam int ADDR_W_D   = 10;
    localparam int LANE_W     = $clog2(POOL_NUM_D);

    typedef struct packed {
        logic [ADDR_W_D-1:0] addr;
        logic [DATA_W_D-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} wb_state_e;
endpackage

// File: rtl/pool_wb_fifo.sv
// pool_wb_fifo: per-lane synchronous FIFO; pushes into a full FIFO survive only with a same-edge pop.
// POOL_WB_OVERFLOW_EN adds a sticky overflow flag for dropped pushes.
module pool_wb_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr, r_rd;
    logic         w_full, w_push, w_pop;
    assign o_empty = r_wr == r_rd;
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
`ifdef POOL_WB_OVERFLOW_EN
    logic r_ovf;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ovf <= 1'b0;
        else if (i_push && !w_push) r_ovf <= 1'b1;
    assign o_overflow = r_ovf;
`else
    assign o_overflow = 1'b0;
`endif
endmodule

// File: rtl/pool_writeback.sv
// pool_writeback: drains 16 pooling-lane FIFOs round-robin into one registered buffer write port.
// POOL_WB_OVERFLOW_EN enables sticky per-lane overflow_o.
module pool_writeback
    import pool_pkg::*;
#(
    parameter int POOL_NUM      = POOL_NUM_D,
    parameter int DATA_WIDTH    = DATA_W_D,
    parameter int ADDRESS_WIDTH = ADDR_W_D,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [POOL_NUM-1:0]               pool_last_i,
    input  logic [POOL_NUM-1:0]               pool_valid_i,
    input  logic [DATA_WIDTH*POOL_NUM-1:0]    pool_result_i,
    input  logic [ADDRESS_WIDTH*POOL_NUM-1:0] pool_result_address_i,
    input  logic                              buf_ready_i,
    output logic                              buf_wr_en_o,
    output logic [ADDRESS_WIDTH+LANE_W-1:0]   buf_addr_o,
    output logic [DATA_WIDTH-1:0]             buf_data_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [POOL_NUM-1:0]               overflow_o
);
    wb_state_e                       r_state;
    logic [POOL_NUM-1:0]             r_last, w_empty, w_pop;
    fifo_entry_t                     w_in [POOL_NUM];
    fifo_entry_t                     w_out [POOL_NUM];
    logic [LANE_W-1:0]               r_rr, w_gnt, w_idx;
    logic                            w_gnt_vld, w_load, w_flush_done;
    logic                            r_wr_en;
    logic [ADDRESS_WIDTH+LANE_W-1:0] r_addr;
    logic [DATA_WIDTH-1:0]           r_data;

    assign w_load = !r_wr_en || buf_ready_i;

    for (genvar k = 0; k < POOL_NUM; k++) begin : g_lane
        assign w_in[k]  = '{addr: pool_result_address_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                            data: pool_result_i[k*DATA_WIDTH +: DATA_WIDTH]};
        assign w_pop[k] = w_load && w_gnt_vld && (w_gnt == LANE_W'(k));
        pool_wb_fifo #(.W($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_push     (pool_valid_i[k]),
            .i_pop      (w_pop[k]),
            .i_data     (w_in[k]),
            .o_data     (w_out[k]),
            .o_empty    (w_empty[k]),
            .o_overflow (overflow_o[k])
        );
    end

    // Scan from the far end so the lane closest to r_rr is the last (winning) assignment.
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int i = POOL_NUM - 1; i >= 0; i--) begin
            w_idx = r_rr + LANE_W'(i);
            if (!w_empty[w_idx]) begin
                w_gnt     = w_idx;
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_flush_done = &w_empty && w_load && !(|pool_valid_i);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rr    <= '0;
        end else if (w_load) begin
            r_wr_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_addr <= {w_gnt, w_out[w_gnt].addr};
                r_data <= w_out[w_gnt].data;
                r_rr   <= w_gnt + LANE_W'(1);
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_last  <= '0;
        end else begin
            r_last <= (r_state == FLUSH && w_flush_done) ? '0 : r_last | pool_last_i;
            case (r_state)
                IDLE:    if (|pool_valid_i || |pool_last_i) r_state <= COLLECT;
                COLLECT: if (&r_last) r_state <= FLUSH;
                FLUSH:   if (w_flush_done) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end

    assign buf_wr_en_o = r_wr_en;
    assign buf_addr_o  = r_addr;
    assign buf_data_o  = r_data;
    assign busy_o      = r_state != IDLE;
    assign done_o      = r_state == DONE;
endmodule

// File: tb/tb_pool_writeback.sv
// tb_pool_writeback: directed self-checking bench for pool_writeback.
// Overflow expectations follow POOL_WB_OVERFLOW_EN.
module tb_pool_writeback;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  pool_last_i = '0;
    logic [15:0]  pool_valid_i = '0;
    logic [127:0] pool_result_i = '0;
    logic [159:0] pool_result_address_i = '0;
    logic         buf_ready_i = 1'b1;
    logic         buf_wr_en_o;
    logic [13:0]  buf_addr_o;
    logic [7:0]   buf_data_o;
    logic         busy_o, done_o;
    logic [15:0]  overflow_o;
    logic [15:0]  exp_ovf;
    int           n_checks = 0;
    int           n_errors = 0;

    pool_writeback dut (
        .clk                   (clk),
        .rst                   (rst),
        .pool_last_i           (pool_last_i),
        .pool_valid_i          (pool_valid_i),
        .pool_result_i         (pool_result_i),
        .pool_result_address_i (pool_result_address_i),
        .buf_ready_i           (buf_ready_i),
        .buf_wr_en_o           (buf_wr_en_o),
        .buf_addr_o            (buf_addr_o),
        .buf_data_o            (buf_data_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .overflow_o            (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b1;
        pool_valid_i = '0;
        pool_last_i = '0;
        buf_ready_i = ready;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [7:0] d, input logic [9:0] a);
        pool_valid_i[k] = 1'b1;
        pool_result_i[k*8 +: 8] = d;
        pool_result_address_i[k*10 +: 10] = a;
    endtask

    task automatic check_wr(input string tag, input int lane, input int a, input int d);
        check({tag, "_en"}, buf_wr_en_o, 1);
        check({tag, "_addr"}, buf_addr_o, (lane << 10) | a);
        check({tag, "_data"}, buf_data_o, d);
    endtask

    initial begin
`ifdef POOL_WB_OVERFLOW_EN
        exp_ovf = 16'h0080;
`else
        exp_ovf = 16'h0000;
`endif
        tick();
        check("rst_wr_en", buf_wr_en_o, 0);
        check("rst_addr", buf_addr_o, 0);
        check("rst_data", buf_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", overflow_o, 0);

        // single write from lane 3
        do_reset(1'b1);
        set_lane(3, 8'h5A, 10'h012);
        tick();
        pool_valid_i = '0;
        check("t1_no_wr_yet", buf_wr_en_o, 0);
        tick();
        check_wr("t1", 3, 'h012, 'h5A);
        check("t1_busy", busy_o, 1);
        tick();
        check("t1_wr_done", buf_wr_en_o, 0);
        check("t1_no_done", done_o, 0);

        // all lanes at once, then all last flags
        do_reset(1'b1);
        for (int k = 0; k < 16; k++) set_lane(k, 8'(8'h10 + k), 10'(k * 5 + 1));
        tick();
        pool_valid_i = '0;
        pool_last_i = '1;
        tick();
        pool_last_i = '0;
        for (int k = 0; k < 16; k++) begin
            check_wr($sformatf("t2_lane%0d", k), k, k * 5 + 1, 'h10 + k);
            check("t2_no_early_done", done_o, 0);
            tick();
        end
        check("t2_done", done_o, 1);
        check("t2_idle_wr", buf_wr_en_o, 0);
        tick();
        check("t2_done_pulse", done_o, 0);
        check("t2_not_busy", busy_o, 0);

        // backpressure holds outputs stable
        do_reset(1'b0);
        set_lane(0, 8'h77, 10'h055);
        tick();
        pool_valid_i = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check_wr($sformatf("t3_hold%0d", c), 0, 'h055, 'h77);
            tick();
        end
        buf_ready_i = 1'b1;
        check_wr("t3_accept", 0, 'h055, 'h77);
        tick();
        check("t3_after", buf_wr_en_o, 0);

        // lane 7 overflow while output register is stalled on lane 0
        do_reset(1'b0);
        set_lane(0, 8'h11, 10'h000);
        tick();
        pool_valid_i = '0;
        for (int i = 0; i < 5; i++) begin
            set_lane(7, 8'(8'h70 + i), 10'(10'h100 + i));
            tick();
        end
        pool_valid_i = '0;
        check("t4_ovf", overflow_o, exp_ovf);
        buf_ready_i = 1'b1;
        check_wr("t4_lane0", 0, 'h000, 'h11);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_wr($sformatf("t4_l7_%0d", i), 7, 'h100 + i, 'h70 + i);
            tick();
        end
        check("t4_drained", buf_wr_en_o, 0);
        check("t4_ovf_sticky", overflow_o, exp_ovf);

        // full FIFO with simultaneous push and pop
        do_reset(1'b0);
        set_lane(0, 8'h22, 10'h000);
        tick();
        pool_valid_i = '0;
        for (int i = 0; i < 4; i++) begin
            set_lane(5, 8'(8'hA0 + i), 10'(10'h200 + i));
            tick();
        end
        set_lane(5, 8'hA4, 10'h204);
        buf_ready_i = 1'b1;
        tick();
        pool_valid_i = '0;
        check("t5_no_ovf", overflow_o, 0);
        for (int i = 0; i < 5; i++) begin
            check_wr($sformatf("t5_l5_%0d", i), 5, 'h200 + i, 'hA0 + i);
            tick();
        end
        check("t5_drained", buf_wr_en_o, 0);

        // reset during FLUSH with pending entries
        do_reset(1'b0);
        for (int k = 0; k < 16; k++) set_lane(k, 8'(k), 10'(k));
        pool_last_i = '1;
        tick();
        pool_valid_i = '0;
        pool_last_i = '0;
        tick();
        tick();
        check("t6_busy", busy_o, 1);
        check("t6_pending", buf_wr_en_o, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_wr", buf_wr_en_o, 0);
        check("t6_rst_addr", buf_addr_o, 0);
        check("t6_rst_data", buf_data_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_done", done_o, 0);
        check("t6_rst_ovf", overflow_o, 0);
        tick();
        rst = 1'b0;
        buf_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_no_wr", buf_wr_en_o, 0);
            check("t6_no_done", done_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
